raizing_soundlatch_bridge: RTL and testbench
============================================

# raizing_soundlatch_bridge

Parametrised mailbox between the 68K main CPU and the Z80 sound CPU on Raizing boards. It generalises the fixed four-latch-plus-ack scheme into N_CH command channels, each with a DEPTH-entry FIFO from main to sound. Each channel also has a single-entry reply latch from sound to main, an NMI pulse generator and a level sound IRQ. It sits in the game top between the CPU block and the sound block, in the 48 MHz domain.

## Interface
Parameters:
- N_CH, 4, number of channels (1..8); CW = max(1, clog2(N_CH))
- DW, 8, data width
- DEPTH, 1, command FIFO depth per channel; power of two, 1..16; DEPTH=1 is a plain latch with pending flag
- NMI_MASK, {N_CH{1'b1}}, per-channel enable for NMI on an accepted command write
- NMI_LEN, 4, NMI pulse length in CLK cycles (1..255)

Ports:
- CLK  in  1  system clock (48 MHz domain, gated by callers via strobes)
- RESET_N  in  1  asynchronous, active-low reset
- M_WR  in  1  main command write strobe, one cycle per write
- M_WCH  in  CW  channel for M_WR
- M_DIN  in  DW  command data
- M_FULL  out  N_CH  channel FIFO full
- M_OVF  out  N_CH  sticky overflow: a write was dropped
- M_OVF_CLR  in  N_CH  per-channel overflow clear
- M_RD  in  1  main reply read strobe
- M_RCH  in  CW  channel for M_RD
- M_DOUT  out  DW  reply data, registered
- M_REPLY_VALID  out  N_CH  reply latch holds unread data
- S_RD  in  1  sound command pop strobe
- S_RCH  in  CW  channel for S_RD
- S_DOUT  out  DW  popped command, registered
- S_PENDING  out  N_CH  channel FIFO non-empty
- S_WR  in  1  sound reply write strobe
- S_WCH  in  CW  channel for S_WR
- S_DIN  in  DW  reply data
- NMI  out  1  NMI pulse to Z80, active high
- SNDIRQ  out  1  OR of S_PENDING

## Operation
- Each channel has a circular FIFO with clog2(DEPTH)-bit read and write pointers and a (clog2(DEPTH)+1)-bit count. Pointers wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.
- Accepted push: M_WR with the channel not full. Data is stored at wptr, wptr increments, count increments.
- M_WR on a full channel: data is dropped, M_OVF[ch] is set, and FIFO state is unchanged.
- Pop: S_RD with the channel non-empty. S_DOUT takes the entry at rptr, rptr increments, count decrements.
- S_RD on an empty channel: S_DOUT and all state are unchanged.
- Push and pop on the same channel in the same cycle:
  - Non-empty: both happen and count is unchanged. This includes the full case; the push is accepted and M_OVF is not set.
  - Empty: the push succeeds and the pop is ignored. S_DOUT is unchanged.
- Out-of-range channel index (≥N_CH): the strobe is ignored entirely.
- Reply latch per channel:
  - S_WR loads the latch and sets M_REPLY_VALID.
  - S_WR while the latch is valid overwrites it (last write wins).
  - M_RD loads M_DOUT from the latch and clears valid.
  - S_WR and M_RD on the same channel in the same cycle: M_DOUT gets the old latch value and valid stays 1 with the new data.
- M_OVF_CLR has priority below a same-cycle overflow set; the set wins.
- NMI generator:
  - An accepted push on a channel with NMI_MASK[ch]=1 loads the counter with NMI_LEN. NMI = (counter != 0); the counter decrements each cycle.
  - A retrigger during a pulse reloads the counter, extending the pulse.
  - A push dropped on full generates no NMI.
- SNDIRQ = |S_PENDING. It is a level signal with no latching.

## Timing
- All outputs are registered except SNDIRQ, which is combinational from registered S_PENDING.
- Reset values: M_FULL=0, M_OVF=0, M_DOUT=0, M_REPLY_VALID=0, S_DOUT=0, S_PENDING=0, NMI=0, SNDIRQ=0. Pointers, counts and the NMI counter are 0. FIFO storage is not reset.
- Strobe at edge t: S_PENDING, M_FULL and M_REPLY_VALID update at t+1. S_DOUT and M_DOUT are valid from t+1 and hold until the next successful read.
- NMI rises at t+1 after an accepted push at t, and stays high for exactly NMI_LEN cycles without retrigger.
- Push-to-pop latency: a pop issued at t+1 returns data pushed at t.
- Reset asserted mid-operation clears everything asynchronously, including any NMI in progress. Release must be synchronised externally.

## Test plan
- Reset with DEPTH=4: all outputs 0. Push 0x11,0x22,0x33,0x44 to ch2 → M_FULL[2]=1 and S_PENDING=4'b0100. A fifth push of 0x55 → M_OVF[2]=1, and popping ×4 yields 0x11,0x22,0x33,0x44 (0x55 is absent).
- Wrap-around with DEPTH=4: 10 alternating push/pop pairs on ch0 with data 0..9 → S_DOUT sequence 0..9 and count 0 at the end. Same-cycle push+pop when full → no overflow and count stays 4.
- NMI with NMI_LEN=4 and NMI_MASK=4'b0011: push ch1 → NMI high for 4 cycles. Push ch3 → NMI stays 0. Push ch0 at cycle 2 of a pulse → total high time 6 cycles.
- Reply path: S_WR ch1 0xA5 → M_REPLY_VALID[1]=1. S_WR 0x5A then M_RD → M_DOUT=0x5A and valid=0. Simultaneous S_WR 0x77 and M_RD → M_DOUT gets the old value and valid=1.
- Edge strobes: pop from an empty channel → S_DOUT unchanged. Write to channel index N_CH → ignored. M_OVF_CLR in the same cycle as an overflow → M_OVF stays 1.
- Assert RESET_N low while NMI is high and FIFOs are non-empty → all outputs 0 immediately. After release, the first pop is ignored.

Source files
------------

// File: rtl/raizing_soundlatch_bridge.sv
// Main-to-sound mailbox: per-channel command FIFOs, single-entry reply latches,
// NMI pulse generator and level sound IRQ.
module raizing_soundlatch_bridge #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int unsigned DW = 8,
    parameter int unsigned DEPTH = 1,
    parameter logic [N_CH-1:0] NMI_MASK = {N_CH{1'b1}},
    parameter int unsigned NMI_LEN = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            M_WR,
    input  logic [CW-1:0]   M_WCH,
    input  logic [DW-1:0]   M_DIN,
    output logic [N_CH-1:0] M_FULL,
    output logic [N_CH-1:0] M_OVF,
    input  logic [N_CH-1:0] M_OVF_CLR,
    input  logic            M_RD,
    input  logic [CW-1:0]   M_RCH,
    output logic [DW-1:0]   M_DOUT,
    output logic [N_CH-1:0] M_REPLY_VALID,
    input  logic            S_RD,
    input  logic [CW-1:0]   S_RCH,
    output logic [DW-1:0]   S_DOUT,
    output logic [N_CH-1:0] S_PENDING,
    input  logic            S_WR,
    input  logic [CW-1:0]   S_WCH,
    input  logic [DW-1:0]   S_DIN,
    output logic            NMI,
    output logic            SNDIRQ
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic [DW-1:0]   fifo_mem [N_CH][DEPTH];
    logic [PW-1:0]   wptr_q   [N_CH];
    logic [PW-1:0]   wptr_d   [N_CH];
    logic [PW-1:0]   rptr_q   [N_CH];
    logic [PW-1:0]   rptr_d   [N_CH];
    logic [CNTW-1:0] count_q  [N_CH];
    logic [CNTW-1:0] count_d  [N_CH];
    logic [DW-1:0]   reply_q  [N_CH];
    logic [DW-1:0]   reply_d  [N_CH];

    logic [N_CH-1:0] w_hit, r_hit, swr_hit, mrd_hit;
    logic [N_CH-1:0] push_ok, pop_ok;
    logic [N_CH-1:0] full_q, full_d, ovf_q, ovf_d, pend_q, pend_d, valid_q, valid_d;
    logic [DW-1:0]   s_dout_q, s_dout_d, m_dout_q, m_dout_d;
    logic [7:0]      nmi_cnt_q, nmi_cnt_d;
    logic            nmi_q, nmi_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    always_comb begin
        s_dout_d = s_dout_q;
        m_dout_d = m_dout_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            // Out-of-range indices never match any channel, so those strobes fall through.
            w_hit[ch]   = M_WR && (M_WCH == CW'(ch));
            r_hit[ch]   = S_RD && (S_RCH == CW'(ch));
            swr_hit[ch] = S_WR && (S_WCH == CW'(ch));
            mrd_hit[ch] = M_RD && (M_RCH == CW'(ch));

            pop_ok[ch]  = r_hit[ch] && (count_q[ch] != '0);
            // A simultaneous pop frees a slot, so a push onto a full FIFO still lands.
            push_ok[ch] = w_hit[ch] && ((count_q[ch] != CNTW'(DEPTH)) || pop_ok[ch]);

            wptr_d[ch]  = push_ok[ch] ? ptr_inc(wptr_q[ch]) : wptr_q[ch];
            rptr_d[ch]  = pop_ok[ch] ? ptr_inc(rptr_q[ch]) : rptr_q[ch];
            count_d[ch] = count_q[ch];
            if (push_ok[ch] && !pop_ok[ch]) count_d[ch] = count_q[ch] + CNTW'(1);
            if (pop_ok[ch] && !push_ok[ch]) count_d[ch] = count_q[ch] - CNTW'(1);

            full_d[ch] = (count_d[ch] == CNTW'(DEPTH));
            pend_d[ch] = (count_d[ch] != '0);

            ovf_d[ch] = ovf_q[ch];
            if (M_OVF_CLR[ch]) ovf_d[ch] = 1'b0;
            if (w_hit[ch] && !push_ok[ch]) ovf_d[ch] = 1'b1;

            if (pop_ok[ch]) s_dout_d = fifo_mem[ch][rptr_q[ch]];

            if (mrd_hit[ch]) m_dout_d = reply_q[ch];
            reply_d[ch] = swr_hit[ch] ? S_DIN : reply_q[ch];
            valid_d[ch] = swr_hit[ch] | (valid_q[ch] & ~mrd_hit[ch]);
        end

        if (|(push_ok & NMI_MASK))  nmi_cnt_d = 8'(NMI_LEN);
        else if (nmi_cnt_q != '0)   nmi_cnt_d = nmi_cnt_q - 8'd1;
        else                        nmi_cnt_d = nmi_cnt_q;
        nmi_d = (nmi_cnt_d != '0);
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge CLK) begin
        for (int ch = 0; ch < N_CH; ch++) begin
            if (push_ok[ch]) fifo_mem[ch][wptr_q[ch]] <= M_DIN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                wptr_q[ch]  <= '0;
                rptr_q[ch]  <= '0;
                count_q[ch] <= '0;
                reply_q[ch] <= '0;
            end
            full_q    <= '0;
            ovf_q     <= '0;
            pend_q    <= '0;
            valid_q   <= '0;
            s_dout_q  <= '0;
            m_dout_q  <= '0;
            nmi_cnt_q <= '0;
            nmi_q     <= 1'b0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                wptr_q[ch]  <= wptr_d[ch];
                rptr_q[ch]  <= rptr_d[ch];
                count_q[ch] <= count_d[ch];
                reply_q[ch] <= reply_d[ch];
            end
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            s_dout_q  <= s_dout_d;
            m_dout_q  <= m_dout_d;
            nmi_cnt_q <= nmi_cnt_d;
            nmi_q     <= nmi_d;
        end
    end

    assign M_FULL        = full_q;
    assign M_OVF         = ovf_q;
    assign M_DOUT        = m_dout_q;
    assign M_REPLY_VALID = valid_q;
    assign S_DOUT        = s_dout_q;
    assign S_PENDING     = pend_q;
    assign NMI           = nmi_q;
    assign SNDIRQ        = |pend_q;

endmodule

// File: tb/tb_raizing_soundlatch_bridge.sv
// Directed bench: 4-channel DEPTH=4 bridge plus a 3-channel DEPTH=1 bridge for
// out-of-range channel indices and the plain-latch case.
module tb_raizing_soundlatch_bridge;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       M_WR = 1'b0, M_RD = 1'b0, S_RD = 1'b0, S_WR = 1'b0;
    logic [1:0] M_WCH = '0, M_RCH = '0, S_RCH = '0, S_WCH = '0;
    logic [7:0] M_DIN = '0, S_DIN = '0;
    logic [3:0] M_OVF_CLR = '0;
    logic [3:0] M_FULL, M_OVF, M_REPLY_VALID, S_PENDING;
    logic [7:0] M_DOUT, S_DOUT;
    logic       NMI, SNDIRQ;

    logic       b_m_wr = 1'b0, b_m_rd = 1'b0, b_s_rd = 1'b0, b_s_wr = 1'b0;
    logic [1:0] b_m_wch = '0, b_m_rch = '0, b_s_rch = '0, b_s_wch = '0;
    logic [7:0] b_m_din = '0, b_s_din = '0;
    logic [2:0] b_m_ovf_clr = '0;
    logic [2:0] b_m_full, b_m_ovf, b_m_reply_valid, b_s_pending;
    logic [7:0] b_m_dout, b_s_dout;
    logic       b_nmi, b_sndirq;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    raizing_soundlatch_bridge #(
        .N_CH(4), .DW(8), .DEPTH(4), .NMI_MASK(4'b0011), .NMI_LEN(4)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .M_WR(M_WR), .M_WCH(M_WCH), .M_DIN(M_DIN), .M_FULL(M_FULL), .M_OVF(M_OVF),
        .M_OVF_CLR(M_OVF_CLR), .M_RD(M_RD), .M_RCH(M_RCH), .M_DOUT(M_DOUT),
        .M_REPLY_VALID(M_REPLY_VALID), .S_RD(S_RD), .S_RCH(S_RCH), .S_DOUT(S_DOUT),
        .S_PENDING(S_PENDING), .S_WR(S_WR), .S_WCH(S_WCH), .S_DIN(S_DIN),
        .NMI(NMI), .SNDIRQ(SNDIRQ)
    );

    raizing_soundlatch_bridge #(
        .N_CH(3), .DW(8), .DEPTH(1), .NMI_MASK(3'b001), .NMI_LEN(2)
    ) u_small (
        .CLK(CLK), .RESET_N(RESET_N),
        .M_WR(b_m_wr), .M_WCH(b_m_wch), .M_DIN(b_m_din), .M_FULL(b_m_full),
        .M_OVF(b_m_ovf), .M_OVF_CLR(b_m_ovf_clr), .M_RD(b_m_rd), .M_RCH(b_m_rch),
        .M_DOUT(b_m_dout), .M_REPLY_VALID(b_m_reply_valid), .S_RD(b_s_rd),
        .S_RCH(b_s_rch), .S_DOUT(b_s_dout), .S_PENDING(b_s_pending), .S_WR(b_s_wr),
        .S_WCH(b_s_wch), .S_DIN(b_s_din), .NMI(b_nmi), .SNDIRQ(b_sndirq)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] d);
        M_WR = 1'b1; M_WCH = ch; M_DIN = d;
        step();
        M_WR = 1'b0;
    endtask

    task automatic pop(input logic [1:0] ch);
        S_RD = 1'b1; S_RCH = ch;
        step();
        S_RD = 1'b0;
    endtask

    task automatic swr(input logic [1:0] ch, input logic [7:0] d);
        S_WR = 1'b1; S_WCH = ch; S_DIN = d;
        step();
        S_WR = 1'b0;
    endtask

    task automatic mrd(input logic [1:0] ch);
        M_RD = 1'b1; M_RCH = ch;
        step();
        M_RD = 1'b0;
    endtask

    task automatic test_reset();
        logic [47:0] flat;
        #12;
        flat = {M_FULL, M_OVF, M_DOUT, M_REPLY_VALID, S_DOUT, S_PENDING, NMI, SNDIRQ, 10'd0};
        tests_run++;
        if (flat !== 48'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", flat);
        end
        tests_run++;
        if ({b_m_full, b_s_pending, b_nmi} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_small: got %b expected 0", {b_m_full, b_s_pending, b_nmi});
        end
        RESET_N = 1'b1;
        step();
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp_data [4];
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) push(2'd2, exp_data[i]);
        tests_run++;
        if (M_FULL !== 4'b0100 || S_PENDING !== 4'b0100 || SNDIRQ !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_full: full=%b pend=%b irq=%b expected 0100 0100 1",
                     M_FULL, S_PENDING, SNDIRQ);
        end
        push(2'd2, 8'h55);
        tests_run++;
        if (M_OVF !== 4'b0100) begin
            tests_failed++;
            $display("FAIL fill_ovf: got %b expected 0100", M_OVF);
        end
        for (int i = 0; i < 4; i++) begin
            pop(2'd2);
            tests_run++;
            if (S_DOUT !== exp_data[i]) begin
                tests_failed++;
                $display("FAIL fill_pop%0d: got %h expected %h", i, S_DOUT, exp_data[i]);
            end
        end
        tests_run++;
        if (S_PENDING !== 4'b0000 || M_FULL !== 4'b0000 || SNDIRQ !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_drained: pend=%b full=%b irq=%b expected 0 0 0",
                     S_PENDING, M_FULL, SNDIRQ);
        end
        M_OVF_CLR = 4'b0100;
        step();
        M_OVF_CLR = '0;
        tests_run++;
        if (M_OVF !== 4'b0000) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %b expected 0000", M_OVF);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            push(2'd0, 8'(i));
            pop(2'd0);
            tests_run++;
            if (S_DOUT !== 8'(i)) begin
                tests_failed++;
                $display("FAIL wrap_pop%0d: got %h expected %h", i, S_DOUT, 8'(i));
            end
        end
        tests_run++;
        if (S_PENDING[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_empty: got %b expected 0", S_PENDING[0]);
        end
        for (int i = 0; i < 4; i++) push(2'd0, 8'hA0 + 8'(i));
        M_WR = 1'b1; M_WCH = 2'd0; M_DIN = 8'hA4;
        S_RD = 1'b1; S_RCH = 2'd0;
        step();
        M_WR = 1'b0; S_RD = 1'b0;
        tests_run++;
        if (S_DOUT !== 8'hA0 || M_OVF[0] !== 1'b0 || M_FULL[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pushpop: dout=%h ovf=%b full=%b expected a0 0 1",
                     S_DOUT, M_OVF[0], M_FULL[0]);
        end
        for (int i = 1; i < 5; i++) begin
            pop(2'd0);
            tests_run++;
            if (S_DOUT !== 8'hA0 + 8'(i)) begin
                tests_failed++;
                $display("FAIL full_drain%0d: got %h expected %h", i, S_DOUT, 8'hA0 + 8'(i));
            end
        end
        tests_run++;
        if (S_PENDING !== 4'b0000) begin
            tests_failed++;
            $display("FAIL full_drained: got %b expected 0000", S_PENDING);
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_nmi();
        int hi;
        tests_run++;
        if (NMI !== 1'b0) begin
            tests_failed++;
            $display("FAIL nmi_idle: got %b expected 0", NMI);
        end
        push(2'd1, 8'h01);
        tests_run++;
        if (NMI !== 1'b1) begin
            tests_failed++;
            $display("FAIL nmi_rise: got %b expected 1", NMI);
        end
        hi = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (NMI === 1'b1) hi++;
        end
        tests_run++;
        if (hi !== 4) begin
            tests_failed++;
            $display("FAIL nmi_len: got %0d cycles expected 4", hi);
        end
        pop(2'd1);

        hi = 0;
        push(2'd3, 8'h03);
        if (NMI === 1'b1) hi++;
        for (int i = 0; i < 6; i++) begin
            step();
            if (NMI === 1'b1) hi++;
        end
        tests_run++;
        if (hi !== 0) begin
            tests_failed++;
            $display("FAIL nmi_masked: got %0d cycles expected 0", hi);
        end
        pop(2'd3);

        hi = 0;
        push(2'd1, 8'h12);
        if (NMI === 1'b1) hi++;
        step();
        if (NMI === 1'b1) hi++;
        push(2'd0, 8'h10);
        if (NMI === 1'b1) hi++;
        for (int i = 0; i < 8; i++) begin
            step();
            if (NMI === 1'b1) hi++;
        end
        tests_run++;
        if (hi !== 6) begin
            tests_failed++;
            $display("FAIL nmi_retrigger: got %0d cycles expected 6", hi);
        end
        pop(2'd0);
        pop(2'd1);
    endtask

    task automatic test_reply();
        swr(2'd1, 8'hA5);
        tests_run++;
        if (M_REPLY_VALID !== 4'b0010) begin
            tests_failed++;
            $display("FAIL reply_valid: got %b expected 0010", M_REPLY_VALID);
        end
        swr(2'd1, 8'h5A);
        mrd(2'd1);
        tests_run++;
        if (M_DOUT !== 8'h5A || M_REPLY_VALID !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reply_read: dout=%h valid=%b expected 5a 0000",
                     M_DOUT, M_REPLY_VALID);
        end
        swr(2'd1, 8'h33);
        S_WR = 1'b1; S_WCH = 2'd1; S_DIN = 8'h77;
        M_RD = 1'b1; M_RCH = 2'd1;
        step();
        S_WR = 1'b0; M_RD = 1'b0;
        tests_run++;
        if (M_DOUT !== 8'h33 || M_REPLY_VALID !== 4'b0010) begin
            tests_failed++;
            $display("FAIL reply_collide: dout=%h valid=%b expected 33 0010",
                     M_DOUT, M_REPLY_VALID);
        end
        mrd(2'd1);
        tests_run++;
        if (M_DOUT !== 8'h77 || M_REPLY_VALID !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reply_after: dout=%h valid=%b expected 77 0000",
                     M_DOUT, M_REPLY_VALID);
        end
    endtask

    task automatic test_edges();
        push(2'd3, 8'h6E);
        pop(2'd3);
        pop(2'd3);
        tests_run++;
        if (S_DOUT !== 8'h6E || S_PENDING !== 4'b0000) begin
            tests_failed++;
            $display("FAIL pop_empty: dout=%h pend=%b expected 6e 0000", S_DOUT, S_PENDING);
        end
        for (int i = 1; i < 5; i++) push(2'd3, 8'(i));
        M_WR = 1'b1; M_WCH = 2'd3; M_DIN = 8'hEE; M_OVF_CLR = 4'b1000;
        step();
        M_WR = 1'b0; M_OVF_CLR = '0;
        tests_run++;
        if (M_OVF !== 4'b1000) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: got %b expected 1000", M_OVF);
        end
        M_OVF_CLR = 4'b1000;
        step();
        M_OVF_CLR = '0;
        for (int i = 0; i < 4; i++) pop(2'd3);
        tests_run++;
        if (M_OVF !== 4'b0000 || S_DOUT !== 8'd4 || S_PENDING !== 4'b0000) begin
            tests_failed++;
            $display("FAIL ovf_clr_drain: ovf=%b dout=%h pend=%b expected 0000 04 0000",
                     M_OVF, S_DOUT, S_PENDING);
        end

        b_m_wr = 1'b1; b_m_wch = 2'd3; b_m_din = 8'h99;
        b_s_wr = 1'b1; b_s_wch = 2'd3; b_s_din = 8'h42;
        step();
        b_m_wr = 1'b0; b_s_wr = 1'b0;
        tests_run++;
        if ({b_s_pending, b_m_full, b_m_ovf, b_m_reply_valid, b_nmi} !== 13'd0) begin
            tests_failed++;
            $display("FAIL out_of_range: got %b expected 0",
                     {b_s_pending, b_m_full, b_m_ovf, b_m_reply_valid, b_nmi});
        end
        b_m_wr = 1'b1; b_m_wch = 2'd0; b_m_din = 8'h3C;
        step();
        tests_run++;
        if (b_m_full !== 3'b001 || b_s_pending !== 3'b001 || b_nmi !== 1'b1) begin
            tests_failed++;
            $display("FAIL latch_push: full=%b pend=%b nmi=%b expected 001 001 1",
                     b_m_full, b_s_pending, b_nmi);
        end
        b_m_din = 8'h99;
        step();
        b_m_wr = 1'b0;
        b_s_rd = 1'b1; b_s_rch = 2'd0;
        step();
        b_s_rd = 1'b0;
        tests_run++;
        if (b_m_ovf !== 3'b001 || b_s_dout !== 8'h3C || b_s_pending !== 3'b000) begin
            tests_failed++;
            $display("FAIL latch_ovf_pop: ovf=%b dout=%h pend=%b expected 001 3c 000",
                     b_m_ovf, b_s_dout, b_s_pending);
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] flat;
        swr(2'd2, 8'h44);
        push(2'd0, 8'hC1);
        push(2'd1, 8'hC2);
        tests_run++;
        if (NMI !== 1'b1 || S_PENDING !== 4'b0011) begin
            tests_failed++;
            $display("FAIL pre_reset: nmi=%b pend=%b expected 1 0011", NMI, S_PENDING);
        end
        #1;
        RESET_N = 1'b0;
        #1;
        flat = {M_FULL, M_OVF, M_DOUT, M_REPLY_VALID, S_DOUT, S_PENDING, NMI, SNDIRQ, 10'd0};
        tests_run++;
        if (flat !== 48'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got %h expected 0", flat);
        end
        #10;
        RESET_N = 1'b1;
        step();
        pop(2'd0);
        tests_run++;
        if (S_DOUT !== 8'h00 || S_PENDING !== 4'b0000 || NMI !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_pop: dout=%h pend=%b nmi=%b expected 00 0000 0",
                     S_DOUT, S_PENDING, NMI);
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_nmi();
        test_reply();
        test_edges();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
